serial_mult_ctrl: RTL

Sequencer for the shift-and-add serial multiplier datapath.
- Loads the multiplicand and multiplier shift registers and clears the accumulator.
- Examines one multiplier bit per iteration, issues an add when that bit is 1, and shifts the operand registers.
- Counts WIDTH iterations, then holds DONE until the consumer acknowledges the result.
- Sits between the top-level start/result handshake and the operand/accumulator registers.

---
 rtl/serial_mult_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/serial_mult_ctrl.sv
// rtl/serial_mult_ctrl.sv - sequencer for a shift-and-add serial multiplier datapath
module serial_mult_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MPLR_BIT,
  input  logic             ACK,
  output logic             LOAD,
  output logic             ACC_CLR,
  output logic             ADD_EN,
  output logic             SHIFT_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (START) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = '0;
        state_d = S_TEST;
      end
      S_TEST: state_d = MPLR_BIT ? S_ADD : S_SHIFT;
      S_ADD:  state_d = S_SHIFT;
      S_SHIFT: begin
        count_d = count_q + CNT_W'(1);
        state_d = (count_q == LAST_ITER) ? S_DONE : S_TEST;
      end
      S_DONE: begin
        // ACK with START chains straight into the next load
        if (ACK) begin
          if (START) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    LOAD     = 1'b0;
    ACC_CLR  = 1'b0;
    ADD_EN   = 1'b0;
    SHIFT_EN = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    case (state_q)
      S_LOAD: begin
        LOAD    = 1'b1;
        ACC_CLR = 1'b1;
        BUSY    = 1'b1;
      end
      S_TEST: BUSY = 1'b1;
      S_ADD: begin
        ADD_EN = 1'b1;
        BUSY   = 1'b1;
      end
      S_SHIFT: begin
        SHIFT_EN = 1'b1;
        BUSY     = 1'b1;
      end
      S_DONE:  DONE = 1'b1;
      default: ;
    endcase
  end

  assign COUNT = count_q;

endmodule
